// File: rtl/alu_pkg.sv
// Shared definitions for the ALU sequencer: opcodes, FSM state encoding and default width.
// Imported by the opcode decoder and by the sequencer top.
package alu_pkg;

    localparam int DEFAULT_WIDTH = 4;

    localparam logic [3:0] OP_ADD = 4'd0;
    localparam logic [3:0] OP_SUB = 4'd1;
    localparam logic [3:0] OP_LSH = 4'd2;
    localparam logic [3:0] OP_RSH = 4'd3;
    localparam logic [3:0] OP_AND = 4'd4;
    localparam logic [3:0] OP_OR  = 4'd5;
    localparam logic [3:0] OP_XOR = 4'd6;
    localparam logic [3:0] OP_INV = 4'd7;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_LOAD    = 3'd1,
        ST_EXEC    = 3'd2,
        ST_CAPTURE = 3'd3,
        ST_RESP    = 3'd4
    } seq_state_t;

endpackage

// File: rtl/alu_op_decode.sv
// Combinational opcode decoder: one-hot ALU strobes (bit index == opcode) while executing,
// plus the operation class flags the sequencer needs for sequencing and flag capture.
module alu_op_decode
    import alu_pkg::*;
(
    input  logic [3:0] i_op,
    input  logic       i_exec,
    output logic [7:0] o_strobes,
    output logic       o_is_shift,
    output logic       o_is_arith,
    output logic       o_is_illegal
);

    always_comb begin
        // NOTE: every output gets a default before any conditional assignment, so no latch is inferred.
        o_strobes    = '0;
        o_is_shift   = (i_op == OP_LSH) || (i_op == OP_RSH);
        o_is_arith   = (i_op == OP_ADD) || (i_op == OP_SUB);
        o_is_illegal = i_op[3];
        if (i_exec && !o_is_illegal) begin
            o_strobes[i_op[2:0]] = 1'b1;
        end
    end

endmodule

// File: rtl/alu_sequencer.sv
// Request/response sequencer for the registered 4-bit ALU: accepts one operation, drives the
// ALU strobes (with a shifter load cycle ahead of shifts) and returns the captured result and flags.
module alu_sequencer
    import alu_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [3:0]       req_op,
    input  logic [WIDTH-1:0] req_a,
    input  logic [WIDTH-1:0] req_b,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_data,
    output logic             rsp_overflow,
    output logic             rsp_shift_flag,
    output logic             rsp_err,
    output logic             alu_add,
    output logic             alu_sub,
    output logic             alu_lsh,
    output logic             alu_rsh,
    output logic             alu_and,
    output logic             alu_or,
    output logic             alu_xor,
    output logic             alu_inv,
    output logic             alu_lsr,
    output logic [WIDTH-1:0] alu_in1,
    output logic [WIDTH-1:0] alu_in2,
    input  logic [WIDTH-1:0] alu_out,
    input  logic             alu_overflow,
    input  logic             alu_shift_flag
);

    seq_state_t       r_state;
    seq_state_t       w_state_next;
    logic [3:0]       r_op;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_rsp_data;
    logic             r_rsp_overflow;
    logic             r_rsp_shift_flag;
    logic             r_rsp_err;

    logic [3:0]       w_dec_op;
    logic             w_exec;
    logic [7:0]       w_strobes;
    logic             w_is_shift;
    logic             w_is_arith;
    logic             w_is_illegal;

    // In IDLE the incoming opcode is classified to pick the next state; afterwards the latched one.
    assign w_dec_op = (r_state == ST_IDLE) ? req_op : r_op;
    assign w_exec   = (r_state == ST_EXEC);

    alu_op_decode u_op_decode (
        .i_op         (w_dec_op),
        .i_exec       (w_exec),
        .o_strobes    (w_strobes),
        .o_is_shift   (w_is_shift),
        .o_is_arith   (w_is_arith),
        .o_is_illegal (w_is_illegal)
    );

    // NOTE: sequential state uses non-blocking assignments; reset here is synchronous, sampled on clk.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        req_ready    = 1'b0;
        rsp_valid    = 1'b0;
        alu_lsr      = 1'b0;
        alu_in1      = '0;
        alu_in2      = '0;
        case (r_state)
            ST_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    if (w_is_illegal)    w_state_next = ST_RESP;
                    else if (w_is_shift) w_state_next = ST_LOAD;
                    else                 w_state_next = ST_EXEC;
                end
            end
            ST_LOAD: begin
                alu_lsr      = 1'b1;
                alu_in1      = r_a;
                alu_in2      = r_b;
                w_state_next = ST_EXEC;
            end
            ST_EXEC: begin
                alu_in1      = r_a;
                alu_in2      = r_b;
                w_state_next = ST_CAPTURE;
            end
            ST_CAPTURE: begin
                alu_in1      = r_a;
                alu_in2      = r_b;
                w_state_next = ST_RESP;
            end
            ST_RESP: begin
                rsp_valid = 1'b1;
                alu_in1   = r_a;
                alu_in2   = r_b;
                if (rsp_ready) w_state_next = ST_IDLE;
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    assign {alu_inv, alu_xor, alu_or, alu_and, alu_rsh, alu_lsh, alu_sub, alu_add} = w_strobes;

    // The shift flag is only meaningful while the shift strobe is up, hence captured in EXEC.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_op             <= '0;
            r_a              <= '0;
            r_b              <= '0;
            r_rsp_data       <= '0;
            r_rsp_overflow   <= 1'b0;
            r_rsp_shift_flag <= 1'b0;
            r_rsp_err        <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (req_valid) begin
                        r_op             <= req_op;
                        r_a              <= req_a;
                        r_b              <= req_b;
                        r_rsp_data       <= '0;
                        r_rsp_overflow   <= 1'b0;
                        r_rsp_shift_flag <= 1'b0;
                        r_rsp_err        <= w_is_illegal;
                    end
                end
                ST_EXEC: begin
                    if (w_is_shift) r_rsp_shift_flag <= alu_shift_flag;
                end
                ST_CAPTURE: begin
                    r_rsp_data     <= alu_out;
                    r_rsp_overflow <= w_is_arith & alu_overflow;
                end
                default: ;
            endcase
        end
    end

    assign rsp_data       = r_rsp_data;
    assign rsp_overflow   = r_rsp_overflow;
    assign rsp_shift_flag = r_rsp_shift_flag;
    assign rsp_err        = r_rsp_err;

endmodule

// File: tb/tb_alu_sequencer.sv
// Directed bench for alu_sequencer with a small registered-ALU model; outputs are sampled on
// the falling edge, and a strobe monitor records when each control line was seen high.
`timescale 1ns/1ps
module tb_alu_sequencer;
    import alu_pkg::*;

    localparam int W = DEFAULT_WIDTH;

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic         req_valid = 1'b0;
    logic         req_ready;
    logic [3:0]   req_op = '0;
    logic [W-1:0] req_a = '0;
    logic [W-1:0] req_b = '0;
    logic         rsp_valid;
    logic         rsp_ready = 1'b0;
    logic [W-1:0] rsp_data;
    logic         rsp_overflow, rsp_shift_flag, rsp_err;
    logic         alu_add, alu_sub, alu_lsh, alu_rsh, alu_and, alu_or, alu_xor, alu_inv, alu_lsr;
    logic [W-1:0] alu_in1, alu_in2, alu_out;
    logic         alu_overflow, alu_shift_flag;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int t_acc   = 0;
    int first_seen [9];
    int seen_cnt   [9];
    int onehot_viol = 0;
    logic [W-1:0] in1_at_strobe = '0;
    logic [W-1:0] in2_at_strobe = '0;

    // index: 0 add,1 sub,2 lsh,3 rsh,4 and,5 or,6 xor,7 inv,8 lsr
    logic [8:0] w_ctl;
    assign w_ctl = {alu_lsr, alu_inv, alu_xor, alu_or, alu_and, alu_rsh, alu_lsh, alu_sub, alu_add};

    alu_sequencer #(.WIDTH(W)) dut (
        .clk            (clk),
        .reset          (reset),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_op         (req_op),
        .req_a          (req_a),
        .req_b          (req_b),
        .rsp_valid      (rsp_valid),
        .rsp_ready      (rsp_ready),
        .rsp_data       (rsp_data),
        .rsp_overflow   (rsp_overflow),
        .rsp_shift_flag (rsp_shift_flag),
        .rsp_err        (rsp_err),
        .alu_add        (alu_add),
        .alu_sub        (alu_sub),
        .alu_lsh        (alu_lsh),
        .alu_rsh        (alu_rsh),
        .alu_and        (alu_and),
        .alu_or         (alu_or),
        .alu_xor        (alu_xor),
        .alu_inv        (alu_inv),
        .alu_lsr        (alu_lsr),
        .alu_in1        (alu_in1),
        .alu_in2        (alu_in2),
        .alu_out        (alu_out),
        .alu_overflow   (alu_overflow),
        .alu_shift_flag (alu_shift_flag)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // ALU model: registered result/overflow (overflow only updated by ADD/SUB), shifter loaded
    // by alu_lsr, shift flag = shifter MSB while a shift strobe is high.
    logic [W-1:0] m_shreg = '0;
    logic [W-1:0] m_out   = '0;
    logic         m_ovf   = 1'b0;
    always @(posedge clk) begin
        if (alu_lsr) m_shreg <= alu_in1;
        if (alu_add)      {m_ovf, m_out} <= {1'b0, alu_in1} + {1'b0, alu_in2};
        else if (alu_sub) begin m_out <= alu_in1 - alu_in2; m_ovf <= (alu_in1 < alu_in2); end
        else if (alu_lsh) m_out <= m_shreg << 1;
        else if (alu_rsh) m_out <= m_shreg >> 1;
        else if (alu_and) m_out <= alu_in1 & alu_in2;
        else if (alu_or)  m_out <= alu_in1 | alu_in2;
        else if (alu_xor) m_out <= alu_in1 ^ alu_in2;
        else if (alu_inv) m_out <= ~alu_in1;
    end
    assign alu_out        = m_out;
    assign alu_overflow   = m_ovf;
    assign alu_shift_flag = (alu_lsh | alu_rsh) & m_shreg[W-1];

    always @(negedge clk) begin
        if ($countones(w_ctl) > 1) onehot_viol++;
        for (int i = 0; i < 9; i++) begin
            if (w_ctl[i]) begin
                seen_cnt[i]++;
                if (first_seen[i] < 0) first_seen[i] = cyc;
            end
        end
        if (w_ctl[7:0] != 8'h00) begin
            in1_at_strobe = alu_in1;
            in2_at_strobe = alu_in2;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic clear_mon();
        for (int i = 0; i < 9; i++) begin
            first_seen[i] = -1;
            seen_cnt[i]   = 0;
        end
    endtask

    function automatic int ctl_total();
        int s = 0;
        for (int i = 0; i < 9; i++) s += seen_cnt[i];
        return s;
    endfunction

    task automatic check_idle(input string tag);
        check({tag, "_ready"}, req_ready, 1);
        check({tag, "_valid"}, rsp_valid, 0);
        check({tag, "_data"}, rsp_data, 0);
        check({tag, "_flags"}, {rsp_overflow, rsp_shift_flag, rsp_err}, 0);
        check({tag, "_ctl"}, w_ctl, 0);
        check({tag, "_in"}, {alu_in1, alu_in2}, 0);
    endtask

    // Called at a negedge in IDLE; returns at the negedge after the accept edge.
    task automatic issue(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        clear_mon();
        req_op    = op;
        req_a     = a;
        req_b     = b;
        req_valid = 1'b1;
        @(negedge clk);
        t_acc     = cyc - 1;
        req_valid = 1'b0;
        req_a     = ~a;
        req_b     = ~b;
    endtask

    task automatic wait_rsp(output int lat);
        lat = -1;
        for (int i = 0; i < 16; i++) begin
            if (rsp_valid) begin
                lat = cyc - t_acc;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic finish_rsp();
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
    endtask

    task automatic run_op(input string tag, input logic [3:0] op, input logic [W-1:0] a,
                          input logic [W-1:0] b, input int exp_lat, input logic [W-1:0] exp_data,
                          input logic exp_ovf, input logic exp_sf, input logic exp_err);
        int lat;
        issue(op, a, b);
        wait_rsp(lat);
        check({tag, "_latency"}, lat, exp_lat);
        check({tag, "_data"}, rsp_data, exp_data);
        check({tag, "_overflow"}, rsp_overflow, exp_ovf);
        check({tag, "_shift_flag"}, rsp_shift_flag, exp_sf);
        check({tag, "_err"}, rsp_err, exp_err);
        finish_rsp();
    endtask

    initial begin
        #50000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        int changes;
        int silent;
        logic [W+2:0] snap;

        clear_mon();
        reset = 1'b0;
        repeat (3) @(negedge clk);
        check_idle("reset");
        reset = 1'b1;
        @(negedge clk);

        run_op("add", OP_ADD, 4'd9, 4'd8, 3, 4'h1, 1'b1, 1'b0, 1'b0);
        check("add_strobe_cycle", first_seen[0] - t_acc, 1);
        check("add_strobe_count", seen_cnt[0], 1);
        check("add_in1", in1_at_strobe, 4'd9);
        check("add_in2", in2_at_strobe, 4'd8);

        run_op("sub", OP_SUB, 4'd3, 4'd5, 3, 4'hE, 1'b1, 1'b0, 1'b0);

        run_op("lsh", OP_LSH, 4'b1001, 4'd0, 4, 4'b0010, 1'b0, 1'b1, 1'b0);
        check("lsh_lsr_cycle", first_seen[8] - t_acc, 1);
        check("lsh_strobe_cycle", first_seen[2] - t_acc, 2);
        check("lsh_ctl_count", ctl_total(), 2);

        run_op("xor", OP_XOR, 4'hA, 4'hF, 3, 4'h5, 1'b0, 1'b0, 1'b0);
        check("xor_strobe_cycle", first_seen[6] - t_acc, 1);

        run_op("rsh", OP_RSH, 4'b0011, 4'd0, 4, 4'b0001, 1'b0, 1'b0, 1'b0);
        check("rsh_strobe_cycle", first_seen[3] - t_acc, 2);

        run_op("illegal", 4'hC, 4'h5, 4'h3, 1, 4'h0, 1'b0, 1'b0, 1'b1);
        check("illegal_ctl_count", ctl_total(), 0);

        // Back-pressure: RESP held for 5 cycles while a new request waits at the port.
        issue(OP_ADD, 4'd7, 4'd9);
        wait_rsp(lat);
        check("bp_latency", lat, 3);
        check("bp_data", rsp_data, 4'h0);
        check("bp_overflow", rsp_overflow, 1);
        snap      = {rsp_data, rsp_overflow, rsp_shift_flag, rsp_err};
        req_op    = OP_AND;
        req_a     = 4'h6;
        req_b     = 4'h3;
        req_valid = 1'b1;
        changes   = 0;
        repeat (5) begin
            @(negedge clk);
            if (snap != {rsp_data, rsp_overflow, rsp_shift_flag, rsp_err} || !rsp_valid || req_ready)
                changes++;
        end
        check("bp_hold", changes, 0);
        clear_mon();
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        check("reaccept_ready", req_ready, 1);
        check("reaccept_no_rsp", rsp_valid, 0);
        check("reaccept_no_ctl", ctl_total(), 0);
        @(negedge clk);
        t_acc     = cyc - 1;
        req_valid = 1'b0;
        check("reaccept_busy", req_ready, 0);
        wait_rsp(lat);
        check("reaccept_latency", lat, 3);
        check("reaccept_data", rsp_data, 4'h2);
        check("reaccept_and_cycle", first_seen[4] - t_acc, 1);
        finish_rsp();

        // Reset while an ADD is in EXEC: operation discarded, no response.
        issue(OP_ADD, 4'd5, 4'd6);
        check("rmid_in_exec", alu_add, 1);
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        check_idle("rmid");
        silent = 0;
        repeat (6) begin
            @(negedge clk);
            if (rsp_valid) silent++;
        end
        check("rmid_no_rsp", silent, 0);
        run_op("and", OP_AND, 4'hC, 4'hA, 3, 4'h8, 1'b0, 1'b0, 1'b0);

        check("onehot0", onehot_viol, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
